// File: rtl/i2c_master_byte_ctrl.sv
// i2c_master_byte_ctrl: byte-level single-master I2C initiator (START/WRITE/READ/STOP).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_op 00 START, 01 WRITE, 10 READ, 11 STOP
//   cmd_wdata               byte sent by WRITE
//   cmd_nack_on_read        READ: 1 = NACK after the byte, 0 = ACK
//   rsp_valid               one-cycle completion pulse with rsp_rdata / rsp_ack / rsp_err
//   busy                    bus owned between START and STOP
//   scl_oe, sda_oe          open-drain pull-low enables; scl_i, sda_i pad inputs
// Optional feature: define I2C_CLK_STRETCH_EN to let a slave stretch SCL at the start of q1.
module i2c_master_byte_ctrl #(
  parameter int I2C_DATA_WIDTH = 8,
  parameter int QTR_DIV = 25
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [I2C_DATA_WIDTH-1:0] cmd_wdata,
  input  logic                      cmd_nack_on_read,
  output logic                      rsp_valid,
  output logic [I2C_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_ack,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      scl_oe,
  output logic                      sda_oe,
  input  logic                      scl_i,
  input  logic                      sda_i
);
  localparam int QW = $clog2(QTR_DIV);
  typedef enum logic [3:0] {IDLE, START, RSTART, WBIT, WACK, RBIT, RACK, STOP, ERR, RESP} state_t;
  state_t state, nxt;
  logic [1:0] scl_s, sda_s;
  logic scl_sync, sda_sync;
  logic [QW-1:0] qcnt;
  logic [1:0] q;
  logic [3:0] bcnt;
  logic [I2C_DATA_WIDTH-1:0] sreg;
  logic nack, sda_last;
  logic active, accept, illegal, stall, qend, bit_end, sample, last_bit, edge_q;
  assign scl_sync = scl_s[1];
  assign sda_sync = sda_s[1];
  assign cmd_ready = state == IDLE || state == RESP;
  assign rsp_valid = state == RESP;
  assign active = !(state inside {IDLE, ERR, RESP});
  assign accept = cmd_valid && cmd_ready;
  assign illegal = cmd_op != 2'b00 && !busy;
  assign qend = qcnt == QW'(QTR_DIV - 1);
  assign bit_end = active && qend && q == 2'd3;
  assign sample = active && qend && q == 2'd1;
  assign last_bit = bcnt == 4'(I2C_DATA_WIDTH - 1);
  assign edge_q = q == 2'd0 || q == 2'd3;
`ifdef I2C_CLK_STRETCH_EN
  // SCL was just released; wait for the pad to actually read high before timing q1
  assign stall = q == 2'd1 && qcnt == '0 && !scl_sync;
`else
  logic unused_scl;
  assign unused_scl = scl_sync;
  assign stall = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, RESP: nxt = !accept ? IDLE : illegal ? ERR :
                        cmd_op == 2'b00 ? (busy ? RSTART : START) :
                        cmd_op == 2'b01 ? WBIT : cmd_op == 2'b10 ? RBIT : STOP;
      ERR: nxt = RESP;
      WBIT: nxt = (bit_end && last_bit) ? WACK : WBIT;
      RBIT: nxt = (bit_end && last_bit) ? RACK : RBIT;
      default: nxt = bit_end ? RESP : state;
    endcase
  end
  // Between commands SCL stays low while the bus is owned and SDA keeps its last level
  always_comb begin
    scl_oe = busy;
    sda_oe = busy & sda_last;
    case (state)
      START: begin scl_oe = q == 2'd3; sda_oe = q[1]; end
      RSTART: begin scl_oe = edge_q; sda_oe = q[1]; end
      WBIT: begin scl_oe = edge_q; sda_oe = ~sreg[I2C_DATA_WIDTH-1]; end
      WACK, RBIT: begin scl_oe = edge_q; sda_oe = 1'b0; end
      RACK: begin scl_oe = edge_q; sda_oe = ~nack; end
      STOP: begin scl_oe = q == 2'd0; sda_oe = !q[1]; end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      qcnt <= '0;
      q <= '0;
      bcnt <= '0;
      sreg <= '0;
      nack <= 1'b0;
      sda_last <= 1'b0;
      rsp_rdata <= '0;
      rsp_ack <= 1'b0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
      sda_last <= sda_oe;
      if (accept) begin
        qcnt <= '0;
        q <= '0;
        bcnt <= '0;
        sreg <= cmd_wdata;
        nack <= cmd_nack_on_read;
        rsp_err <= illegal;
      end else if (active && !stall) begin
        qcnt <= qend ? '0 : qcnt + QW'(1);
        q <= q + {1'b0, qend};
      end
      if (bit_end && (state == WBIT || state == RBIT)) bcnt <= bcnt + 4'd1;
      if (bit_end && state == WBIT) sreg <= sreg << 1;
      if (sample && state == RBIT) sreg <= {sreg[I2C_DATA_WIDTH-2:0], sda_sync};
      if (sample && state == WACK) rsp_ack <= ~sda_sync;
      if (bit_end && state == RACK) rsp_rdata <= sreg;
      if (bit_end && state == START) busy <= 1'b1;
      if (bit_end && state == STOP) busy <= 1'b0;
    end
  end
endmodule
